// File: rtl/m_unit_if.sv
// Request/response bundle between the execute stage and the RV32M multiply/divide unit.
interface m_unit_if;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        flush;
    logic        busy;
    logic        m_unit_ready;
    logic [31:0] m_unit_result;
    logic [4:0]  m_unit_dest;
    logic        m_unit_wr;

    modport master (
        output start, func3, op1, op2, rd, flush,
        input  busy, m_unit_ready, m_unit_result, m_unit_dest, m_unit_wr
    );

    modport slave (
        input  start, func3, op1, op2, rd, flush,
        output busy, m_unit_ready, m_unit_result, m_unit_dest, m_unit_wr
    );
endinterface

// File: rtl/m_unit.sv
// RV32M execution unit: two-cycle registered multiply, 32-step restoring divide,
// with fast paths for divide-by-zero and signed overflow.
module m_unit (
    input logic    clk,
    input logic    rst,
    m_unit_if.slave mu
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, next_state;
    logic [1:0]  f3_q;
    logic [31:0] op1_q, op2_q;
    logic [4:0]  rd_q;
    logic [4:0]  cnt_q;
    logic [31:0] rem_q, quo_q, divisor_q;
    logic        neg_q_q, neg_r_q;
    logic [31:0] result_q;
    logic [4:0]  dest_q;

    logic        accept;
    logic        div_signed, div_zero, div_ovf, div_bypass;
    logic        mul_sa, mul_sb;
    logic [63:0] mul_a, mul_b, product;
    logic [31:0] mul_sel;
    logic [32:0] trial, diff;
    logic [31:0] rem_nx, quo_nx, q_fin, r_fin, div_sel;

    assign accept     = (state == IDLE || state == DONE) && mu.start && !mu.flush;
    assign div_signed = !mu.func3[0];
    assign div_zero   = (mu.op2 == 32'd0);
    assign div_ovf    = div_signed && (mu.op1 == 32'h8000_0000) && (mu.op2 == 32'hFFFF_FFFF);
    assign div_bypass = div_zero || div_ovf;

    // Operand signedness follows the latched func3: MULH both signed, MULHSU only op1.
    assign mul_sa  = (f3_q == 2'b01) || (f3_q == 2'b10);
    assign mul_sb  = (f3_q == 2'b01);
    assign mul_a   = {{32{mul_sa & op1_q[31]}}, op1_q};
    assign mul_b   = {{32{mul_sb & op2_q[31]}}, op2_q};
    assign product = mul_a * mul_b;
    assign mul_sel = (f3_q == 2'b00) ? product[31:0] : product[63:32];

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    always_comb begin
        trial = {rem_q, quo_q[31]};
        diff  = trial - {1'b0, divisor_q};
        if (!diff[32]) begin
            rem_nx = diff[31:0];
            quo_nx = {quo_q[30:0], 1'b1};
        end else begin
            rem_nx = trial[31:0];
            quo_nx = {quo_q[30:0], 1'b0};
        end
        q_fin   = neg_q_q ? (32'd0 - quo_nx) : quo_nx;
        r_fin   = neg_r_q ? (32'd0 - rem_nx) : rem_nx;
        div_sel = f3_q[1] ? r_fin : q_fin;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: begin
                if (mu.start) begin
                    if (!mu.func3[2])   next_state = MUL;
                    else if (div_bypass) next_state = DONE;
                    else                 next_state = DIV;
                end else begin
                    next_state = IDLE;
                end
            end
            MUL:     next_state = DONE;
            DIV:     next_state = (cnt_q == 5'd31) ? DONE : DIV;
            default: next_state = IDLE;
        endcase
        if (mu.flush) next_state = IDLE;
    end

    always_comb begin
        mu.busy         = (state == MUL) || (state == DIV);
        mu.m_unit_ready = (state == DONE);
        mu.m_unit_wr    = (state == DONE) && (dest_q != 5'd0);
    end

    assign mu.m_unit_result = result_q;
    assign mu.m_unit_dest   = dest_q;

    // Result/dest only change on a completion edge, so they hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q      <= 2'd0;
            op1_q     <= 32'd0;
            op2_q     <= 32'd0;
            rd_q      <= 5'd0;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            divisor_q <= 32'd0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            result_q  <= 32'd0;
            dest_q    <= 5'd0;
        end else if (accept) begin
            f3_q      <= mu.func3[1:0];
            op1_q     <= mu.op1;
            op2_q     <= mu.op2;
            rd_q      <= mu.rd;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            neg_q_q   <= div_signed && (mu.op1[31] ^ mu.op2[31]);
            neg_r_q   <= div_signed && mu.op1[31];
            quo_q     <= (div_signed && mu.op1[31]) ? (32'd0 - mu.op1) : mu.op1;
            divisor_q <= (div_signed && mu.op2[31]) ? (32'd0 - mu.op2) : mu.op2;
            if (mu.func3[2] && div_zero) begin
                result_q <= mu.func3[1] ? mu.op1 : 32'hFFFF_FFFF;
                dest_q   <= mu.rd;
            end else if (mu.func3[2] && div_ovf) begin
                result_q <= mu.func3[1] ? 32'd0 : 32'h8000_0000;
                dest_q   <= mu.rd;
            end
        end else if (state == MUL && !mu.flush) begin
            result_q <= mul_sel;
            dest_q   <= rd_q;
        end else if (state == DIV && !mu.flush) begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
                result_q <= div_sel;
                dest_q   <= rd_q;
            end
        end
    end

endmodule

// File: doc/m_unit.md
M_UNIT -- requirements
Module: m_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  execute stage requests an RV32M operation this cycle.
REQ-005 func3  input  3  M-op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op1  input  32  rs1 value, already forwarded.
REQ-007 op2  input  32  rs2 value, already forwarded.
REQ-008 rd  input  5  destination register of the request.
REQ-009 flush  input  1  synchronous abort of any in-flight operation.
REQ-010 busy  output  1  operation in progress; pipeline stalls on it.
REQ-011 m_unit_ready  output  1  one-cycle pulse: result valid.
REQ-012 m_unit_result  output  32  result of the completed operation.
REQ-013 m_unit_dest  output  5  rd of the completed operation.
REQ-014 m_unit_wr  output  1  register-file write enable for the completed operation.

Function
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and DONE; start SHALL be accepted only in IDLE or DONE.
REQ-016 On acceptance, the block SHALL latch func3, op1, op2 and rd; later input changes SHALL NOT affect the result.
REQ-017 MUL path: accept at T -> MUL at T+1 (registered 64-bit product) -> DONE at T+2 with m_unit_ready=1.
REQ-018 MUL SHALL return product[31:0]; MULH signed x signed [63:32]; MULHSU signed op1 x unsigned op2 [63:32]; MULHU unsigned x unsigned [63:32].
REQ-019 DIV path: restoring divide on magnitudes, one quotient bit per cycle, 32 cycles in DIV (T+1..T+32), then DONE at T+33.
REQ-020 Signed quotient sign SHALL be op1[31]^op2[31]; signed remainder sign SHALL follow op1; unsigned ops SHALL use raw operands.
REQ-021 Divide by zero SHALL bypass iteration, entering DONE at T+1: quotient 0xFFFFFFFF, remainder op1, for both signed and unsigned ops.
REQ-022 Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM) SHALL enter DONE at T+1: quotient 0x80000000, remainder 0.
REQ-023 busy SHALL be 1 exactly in MUL and DIV states, and 0 in IDLE and DONE.
REQ-024 m_unit_ready SHALL be 1 only in DONE, for exactly one cycle per operation.
REQ-025 DONE SHALL go to IDLE when start=0, or begin a new operation (MUL or DIV) when start=1.
REQ-026 m_unit_wr SHALL equal m_unit_ready AND (latched rd != 0).
REQ-027 m_unit_result and m_unit_dest SHALL be registered and hold their last values until the next completion.
REQ-028 flush SHALL force IDLE on the next edge with no ready pulse; flush has priority over start in the same cycle.
REQ-029 start in MUL or DIV SHALL be ignored; the current operation is not disturbed.

Reset
REQ-030 On rst=1, the block SHALL go to IDLE immediately, independent of clk.
REQ-031 Reset values SHALL be busy=0, m_unit_ready=0, m_unit_wr=0, m_unit_result=0, m_unit_dest=0, and all internal registers 0.
REQ-032 A reset mid-operation SHALL discard the operation with no ready pulse; the first start after rst falls SHALL be accepted normally.

Verification
REQ-033 MULH op1=0xFFFFFFFF, op2=0xFFFFFFFF, rd=5 -> ready at T+2, result 0x00000000, dest 5, wr 1; MULHU same operands -> 0xFFFFFFFE.
REQ-034 DIV op1=-7 (0xFFFFFFF9), op2=2 -> ready at T+33, result 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; busy high T+1..T+32.
REQ-035 DIVU op1=100, op2=0 -> ready at T+1, result 0xFFFFFFFF; REMU same operands -> 100.
REQ-036 DIV op1=0x80000000, op2=0xFFFFFFFF -> ready at T+1, result 0x80000000; REM same operands -> 0.
REQ-037 Assert rst at cycle 10 of a DIV -> busy=0 with no ready; MUL 3x4 with rd=0 afterwards -> result 12, wr 0.
REQ-038 flush at cycle 5 of a DIV -> IDLE, no ready. Back-to-back: start asserted in DONE -> new operation accepted, ready pulses are not merged.
